fb_scanout_reader: RTL and testbench
====================================

FB_SCANOUT_READER -- requirements
Module: fb_scanout_reader

Parameters
REQ-001 SHALL have parameter H_PIXELS, default 160, meaning pixels per framebuffer line.
REQ-002 SHALL have parameter V_LINES, default 240, meaning lines per frame.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning prefetch FIFO entries (power of 2, at least 2).

Interface
REQ-004 SHALL have port iCLK, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port iRST, input, 1, reset; asynchronous and active-high.
REQ-006 SHALL have port iFrameStart, input, 1, one-cycle pulse that starts or restarts frame scan-out at pixel (0,0).
REQ-007 SHALL have port iGrant, input, 1, high when the SRAM read slot is available this cycle (low while the pixel writer owns SRAM).
REQ-008 SHALL have port oSramRd, output, 1, SRAM read strobe.
REQ-009 SHALL have port oSramAddr, output, 18, read address {x[8:0], y[8:0]}.
REQ-010 SHALL have port iSramData, input, 8, TIA color byte {hue[7:4], lum[3:0]}, valid exactly 1 cycle after oSramRd.
REQ-011 SHALL have ports oPixValid (output, 1), oPixColor (output, 8) and iPixReady (input, 1), forming the valid/ready pixel output stream.
REQ-012 SHALL have port oFrameDone, output, 1, one-cycle pulse when the last pixel of a frame is accepted.
REQ-013 SHALL have port oUnderrun, output, 1, one-cycle pulse when iPixReady is high, the FIFO is empty and the state is FETCH or DRAIN.

Function
REQ-014 SHALL implement states IDLE, FETCH and DRAIN.
REQ-015 SHALL transition from IDLE to FETCH on iFrameStart, with x=0 and y=0.
REQ-016 SHALL, in FETCH, assert oSramRd only when iGrant=1 and (count + inflight) < FIFO_DEPTH; oSramAddr is valid in the same cycle.
REQ-017 SHALL, on each issued read, increment x; at x=H_PIXELS-1, wrap x to 0 and increment y.
REQ-018 SHALL, when the read for (H_PIXELS-1, V_LINES-1) is issued, transition to DRAIN and issue no further reads.
REQ-019 SHALL push iSramData into the FIFO on the cycle after each issued read, unless that read was discarded (REQ-024).
REQ-020 SHALL drive oPixValid high whenever the FIFO is not empty, with oPixColor equal to the FIFO head; a pop occurs only when oPixValid and iPixReady are both high.
REQ-021 SHALL, on simultaneous push and pop, leave count unchanged and preserve data order; the FIFO never overflows, because REQ-016 reserves space for in-flight data.
REQ-022 SHALL hold oPixColor stable while oPixValid=1 and iPixReady=0.
REQ-023 SHALL, in DRAIN, pulse oFrameDone and enter IDLE on the pop that leaves count=0 with no read in flight.
REQ-024 SHALL, on iFrameStart in FETCH or DRAIN: flush the FIFO, discard any in-flight return data, reset x and y to 0, and enter FETCH on the next cycle, with no oFrameDone pulse.
REQ-025 SHALL ignore iGrant in IDLE and DRAIN (oSramRd=0).
REQ-026 SHALL zero-extend x and y to 9 bits each in oSramAddr.

Reset
REQ-027 SHALL, while iRST=1, force state IDLE, x=0, y=0, count=0, inflight=0, oSramRd=0, oSramAddr=0, oPixValid=0, oPixColor=0, oFrameDone=0 and oUnderrun=0.
REQ-028 SHALL, when iRST is asserted mid-frame, abandon the frame immediately; data returning after reset is not captured.
REQ-029 SHALL require an iFrameStart after iRST deasserts before any read is issued.

Verification
REQ-030 SHALL be verified by this scenario: iGrant=1, iPixReady=1, iFrameStart pulse -> first oSramRd with oSramAddr=0x00000 one cycle later; oSramAddr after 160 reads = {9'd0, 9'd1}; exactly 38400 pixels delivered; oFrameDone pulses once.
REQ-031 SHALL be verified by this scenario: iPixReady=0 throughout -> exactly 8 reads issued, then oSramRd=0; oPixValid=1 with oPixColor equal to the first byte returned.
REQ-032 SHALL be verified by this scenario: iGrant toggling 50% randomly with random iPixReady -> output sequence equals the SRAM model contents in raster order, and no overflow occurs.
REQ-033 SHALL be verified by this scenario: iFrameStart at pixel 1000 while a read is in flight -> the FIFO empties, the next delivered pixel is the (0,0) byte, and there is no oFrameDone pulse.
REQ-034 SHALL be verified by this scenario: iGrant=0 for 20 cycles while iPixReady=1 and the FIFO drains -> oUnderrun pulses on each empty-and-ready cycle, and oPixValid=0.
REQ-035 SHALL be verified by this scenario: iRST asserted during DRAIN -> all outputs are 0 asynchronously, and the state stays IDLE until iFrameStart.

Source files
------------

// File: rtl/fb_scanout_reader.sv
// Framebuffer scan-out reader: fetches pixels from SRAM in raster order during
// the read slots granted to it and streams them out through a small prefetch FIFO.
module fb_scanout_reader #(
  parameter int H_PIXELS   = 160,
  parameter int V_LINES    = 240,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iFrameStart,
  input  logic        iGrant,
  output logic        oSramRd,
  output logic [17:0] oSramAddr,
  input  logic [7:0]  iSramData,
  output logic        oPixValid,
  output logic [7:0]  oPixColor,
  input  logic        iPixReady,
  output logic        oFrameDone,
  output logic        oUnderrun,
  output logic [1:0]  oDbgState
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);
  localparam logic [8:0]  X_LAST  = 9'(H_PIXELS - 1);
  localparam logic [8:0]  Y_LAST  = 9'(V_LINES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [8:0]      x_q, x_d;
  logic [8:0]      y_q, y_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic            inflight_q, inflight_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic            fifo_empty;
  logic            has_space;
  logic [CW:0]     used;
  logic            sram_rd;
  logic            flush;
  logic            push;
  logic            pop;
  logic            frame_done;
  logic            underrun;

  // Output stream: oPixValid means the head entry is presented; a transfer
  // happens on any cycle where oPixValid and iPixReady are both high, and the
  // head stays put until that transfer.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    sram_rd    = 1'b0;
    flush      = 1'b0;
    frame_done = 1'b0;

    fifo_empty = (count_q == '0);
    used       = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    has_space  = (used < DEPTH_L);
    pop        = !fifo_empty && iPixReady;
    underrun   = iPixReady && fifo_empty && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (iFrameStart) begin
          state_d = ST_FETCH;
          x_d     = '0;
          y_d     = '0;
        end
      end
      ST_FETCH: begin
        if (iFrameStart) begin
          flush = 1'b1;
        end else if (iGrant && has_space) begin
          sram_rd = 1'b1;
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              y_d     = '0;
              state_d = ST_DRAIN;
            end else begin
              y_d = y_q + 9'd1;
            end
          end else begin
            x_d = x_q + 9'd1;
          end
        end
      end
      ST_DRAIN: begin
        if (iFrameStart) begin
          flush = 1'b1;
        end else if (pop && (count_q == CW'(1)) && !inflight_q) begin
          frame_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A restart drops buffered pixels and the byte returning this cycle.
    if (flush) begin
      state_d = ST_FETCH;
      x_d     = '0;
      y_d     = '0;
    end

    push       = inflight_q && !flush;
    inflight_d = sram_rd;

    if (flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      inflight_q <= inflight_d;
    end
  end

  // Storage needs no reset: the color output is masked while the FIFO is empty.
  always_ff @(posedge iCLK) begin
    if (push) mem_q[wr_ptr_q] <= iSramData;
  end

  assign oSramRd    = sram_rd;
  assign oSramAddr  = {x_q, y_q};
  assign oPixValid  = !fifo_empty;
  assign oPixColor  = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
  assign oFrameDone = frame_done;
  assign oUnderrun  = underrun;
  assign oDbgState  = state_q;

endmodule

// File: tb/tb_fb_scanout_reader.sv
// Bench for fb_scanout_reader: cycle-by-cycle vector table, then full-frame,
// backpressure, random-grant, restart, underrun and reset-in-drain sequences.
module tb_fb_scanout_reader;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iFrameStart = 1'b0;
  logic        iGrant = 1'b0;
  logic        oSramRd;
  logic [17:0] oSramAddr;
  logic [7:0]  iSramData = 8'h00;
  logic        oPixValid;
  logic [7:0]  oPixColor;
  logic        iPixReady = 1'b0;
  logic        oFrameDone;
  logic        oUnderrun;
  logic [1:0]  oDbgState;

  fb_scanout_reader dut (
    .iCLK(iCLK), .iRST(iRST), .iFrameStart(iFrameStart), .iGrant(iGrant),
    .oSramRd(oSramRd), .oSramAddr(oSramAddr), .iSramData(iSramData),
    .oPixValid(oPixValid), .oPixColor(oPixColor), .iPixReady(iPixReady),
    .oFrameDone(oFrameDone), .oUnderrun(oUnderrun), .oDbgState(oDbgState)
  );

  // ---------------- clock ----------------
  always #5 iCLK = ~iCLK;

  // ---------------- SRAM contents model ----------------
  function automatic logic [7:0] pix(input int x, input int y);
    return 8'((x + 3 * y + 17) & 255);
  endfunction

  always @(posedge iCLK)
    iSramData <= oSramRd ? pix(int'(oSramAddr[17:9]), int'(oSramAddr[8:0])) : 8'hEE;

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic       mon_en = 1'b0;
  logic       cap_first = 1'b0;
  logic [7:0] first_pix = 8'h00;
  logic       last_rd = 1'b0;
  int         pix_cnt = 0, bad = 0, rd_cnt = 0, fd_cnt = 0;
  logic [17:0] addr160 = '0;

  always @(negedge iCLK) begin
    logic [7:0] e;
    last_rd = oSramRd;
    if (oSramRd) begin
      if (rd_cnt == 160) addr160 = oSramAddr;
      rd_cnt++;
    end
    if (oFrameDone) fd_cnt++;
    if (mon_en && oPixValid && iPixReady) begin
      pix_cnt++;
      if (cap_first) begin
        first_pix = oPixColor;
        cap_first = 1'b0;
      end
      if (exp_q.size() == 0) bad++;
      else begin
        e = exp_q.pop_front();
        if (e !== oPixColor) bad++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    pix_cnt = 0; bad = 0; rd_cnt = 0; fd_cnt = 0; addr160 = '0;
  endtask

  task automatic fill_raster();
    exp_q.delete();
    for (int y = 0; y < 240; y++)
      for (int x = 0; x < 160; x++)
        exp_q.push_back(pix(x, y));
  endtask

  task automatic do_reset();
    @(posedge iCLK); #1;
    iRST = 1'b1; iFrameStart = 1'b0; iGrant = 1'b0; iPixReady = 1'b0;
    repeat (2) @(posedge iCLK);
    #1 iRST = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        fs, g, r;
    logic        rd;
    logic [17:0] addr;
    logic        valid;
    logic [7:0]  color;
    logic        und;
  } vec_t;

  function automatic vec_t mk(input logic fs, input logic g, input logic r, input logic rd,
                              input logic [17:0] addr, input logic valid,
                              input logic [7:0] color, input logic und);
    vec_t v;
    v.fs = fs; v.g = g; v.r = r; v.rd = rd;
    v.addr = addr; v.valid = valid; v.color = color; v.und = und;
    return v;
  endfunction

  vec_t vecs[13];

  initial begin
    int found;
    int und_l, val_l, mism, rd_l;

    vecs[0]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 18'h00000, 1'b0, 8'h00, 1'b0);
    vecs[1]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 18'h00000, 1'b0, 8'h00, 1'b0);
    vecs[2]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 18'h00200, 1'b0, 8'h00, 1'b0);
    vecs[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 18'h00400, 1'b1, 8'h11, 1'b0);
    vecs[4]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 18'h00400, 1'b1, 8'h11, 1'b0);
    vecs[5]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 18'h00400, 1'b1, 8'h12, 1'b0);
    vecs[6]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 18'h00400, 1'b0, 8'h00, 1'b1);
    vecs[7]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 18'h00400, 1'b0, 8'h00, 1'b1);
    vecs[8]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 18'h00600, 1'b0, 8'h00, 1'b1);
    vecs[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 18'h00600, 1'b1, 8'h13, 1'b0);
    vecs[10] = mk(1'b1, 1'b0, 1'b0, 1'b0, 18'h00600, 1'b1, 8'h13, 1'b0);
    vecs[11] = mk(1'b0, 1'b0, 1'b1, 1'b0, 18'h00000, 1'b0, 8'h00, 1'b1);
    vecs[12] = mk(1'b0, 1'b1, 1'b0, 1'b1, 18'h00000, 1'b0, 8'h00, 1'b0);

    // reset state
    iGrant = 1'b1; iPixReady = 1'b1;
    repeat (3) @(negedge iCLK);
    chk("reset_outputs", 32'({oSramRd, oSramAddr, oPixValid, oPixColor, oFrameDone, oUnderrun}), 32'h0);
    chk("reset_state", 32'(oDbgState), 32'd0);
    @(posedge iCLK); #1 iRST = 1'b0;

    // table: drive just after the edge, compare on the falling edge
    foreach (vecs[i]) begin
      @(posedge iCLK); #1;
      iFrameStart = vecs[i].fs; iGrant = vecs[i].g; iPixReady = vecs[i].r;
      @(negedge iCLK);
      chk($sformatf("vec%0d_rd", i),    32'(oSramRd),   32'(vecs[i].rd));
      chk($sformatf("vec%0d_addr", i),  32'(oSramAddr), 32'(vecs[i].addr));
      chk($sformatf("vec%0d_valid", i), 32'(oPixValid), 32'(vecs[i].valid));
      chk($sformatf("vec%0d_color", i), 32'(oPixColor), 32'(vecs[i].color));
      chk($sformatf("vec%0d_und", i),   32'(oUnderrun), 32'(vecs[i].und));
    end

    // backpressure: reads stop once the FIFO plus in-flight reach its depth
    do_reset();
    clear_counts();
    iGrant = 1'b1; iPixReady = 1'b0; iFrameStart = 1'b1;
    @(posedge iCLK); #1 iFrameStart = 1'b0;
    repeat (30) @(posedge iCLK);
    @(negedge iCLK);
    chk("bp_read_count", 32'(rd_cnt), 32'd8);
    chk("bp_rd_low", 32'(oSramRd), 32'd0);
    chk("bp_valid", 32'(oPixValid), 32'd1);
    chk("bp_head", 32'(oPixColor), 32'h11);

    // full frame at full rate
    do_reset();
    clear_counts();
    fill_raster();
    mon_en = 1'b1;
    iGrant = 1'b1; iPixReady = 1'b1; iFrameStart = 1'b1;
    @(posedge iCLK); #1 iFrameStart = 1'b0;
    @(negedge iCLK);
    chk("frame_first_rd", 32'(oSramRd), 32'd1);
    chk("frame_first_addr", 32'(oSramAddr), 32'h0);
    found = 0;
    for (int c = 0; c < 40000; c++) begin
      @(posedge iCLK); #1;
      if (fd_cnt != 0) begin found = 1; break; end
    end
    chk("frame_done_seen", 32'(found), 32'd1);
    repeat (10) @(posedge iCLK);
    #1;
    chk("frame_addr_after_160", 32'(addr160), 32'h00001);
    chk("frame_reads", 32'(rd_cnt), 32'd38400);
    chk("frame_pixels", 32'(pix_cnt), 32'd38400);
    chk("frame_order", 32'(bad), 32'd0);
    chk("frame_leftover", 32'(exp_q.size()), 32'd0);
    chk("frame_done_once", 32'(fd_cnt), 32'd1);
    chk("frame_idle", 32'(oDbgState), 32'd0);

    // random grant / ready, then restart at pixel 1000 with a read in flight
    clear_counts();
    fill_raster();
    iFrameStart = 1'b1;
    @(posedge iCLK); #1 iFrameStart = 1'b0;
    found = 0;
    for (int c = 0; c < 8000; c++) begin
      @(posedge iCLK); #1;
      if (pix_cnt >= 1000 && last_rd) begin found = 1; break; end
      iGrant = 1'($urandom_range(0, 1));
      iPixReady = 1'($urandom_range(0, 1));
    end
    chk("rand_reached_1000", 32'(found), 32'd1);
    iFrameStart = 1'b1; iGrant = 1'b1; iPixReady = 1'b1;
    @(posedge iCLK); #1 iFrameStart = 1'b0;
    chk("rand_order", 32'(bad), 32'd0);
    clear_counts();
    fill_raster();
    cap_first = 1'b1;
    @(negedge iCLK);
    chk("restart_flushed", 32'(oPixValid), 32'd0);
    @(negedge iCLK);
    chk("restart_discard_inflight", 32'(oPixValid), 32'd0);
    repeat (300) @(posedge iCLK);

    // grant withheld while the consumer keeps pulling
    und_l = 0; val_l = 0; mism = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge iCLK); #1 iGrant = 1'b0; iPixReady = 1'b1;
      @(negedge iCLK);
      if (oUnderrun) und_l++;
      if (oPixValid) val_l++;
      if (oUnderrun == oPixValid) mism++;
    end
    chk("und_vs_valid", 32'(mism), 32'd0);
    chk("und_cycles_total", 32'(und_l + val_l), 32'd20);
    chk("und_min_pulses", 32'(und_l >= 11), 32'd1);
    chk("und_final_valid", 32'(oPixValid), 32'd0);
    chk("und_final_pulse", 32'(oUnderrun), 32'd1);

    // run to DRAIN, then reset asynchronously
    @(posedge iCLK); #1 iGrant = 1'b1;
    found = 0;
    for (int c = 0; c < 40000; c++) begin
      @(negedge iCLK);
      if (oDbgState == 2'd2) begin found = 1; break; end
    end
    chk("drain_reached", 32'(found), 32'd1);
    chk("restart_no_done", 32'(fd_cnt), 32'd0);
    chk("restart_first_pixel", 32'(first_pix), 32'h11);
    chk("restart_order", 32'(bad), 32'd0);
    mon_en = 1'b0;
    #1 iRST = 1'b1;
    #1;
    chk("async_reset_outputs", 32'({oSramRd, oSramAddr, oPixValid, oPixColor, oFrameDone, oUnderrun}), 32'h0);
    chk("async_reset_state", 32'(oDbgState), 32'd0);
    repeat (2) @(posedge iCLK);
    #1 iRST = 1'b0;
    rd_l = 0; val_l = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge iCLK);
      if (oSramRd) rd_l++;
      if (oPixValid) val_l++;
    end
    chk("post_reset_no_reads", 32'(rd_l), 32'd0);
    chk("post_reset_no_pixels", 32'(val_l), 32'd0);
    chk("post_reset_idle", 32'(oDbgState), 32'd0);
    @(posedge iCLK); #1 iFrameStart = 1'b1;
    @(posedge iCLK); #1 iFrameStart = 1'b0;
    @(negedge iCLK);
    chk("post_reset_fs_read", 32'(oSramRd), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
